// File: rtl/hdmi_packet_assembler.sv
// HDMI data island packet serialiser: 24-bit header + four 56-bit subpackets -> 32 x 9-bit pixels.
// Define HDMI_PACKET_ECC_EN to generate BCH parity; otherwise the parity slots carry zeros.
module hdmi_packet_assembler #(
   parameter int PACKET_COUNT_MAX = 18
) (
   input  logic         clk_pixel,
   input  logic         reset_n,
   input  logic         packet_enable,
   input  logic [23:0]  header,
   input  logic [223:0] sub,
   output logic [8:0]   packet_data,
   output logic [4:0]   packet_counter,
   output logic         busy,
   output logic         packet_last
);

   localparam int RUN_W = $clog2(PACKET_COUNT_MAX + 1);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t           r_state;
   logic [RUN_W-1:0] r_run;
   logic             r_blocked;
   logic [23:0]      r_hdr_sr;
   logic [55:0]      r_sub_sr [4];

   logic             w_load;
   logic             w_active;
   logic [4:0]       w_cnt_next;
   logic [8:0]       w_data;
   logic [23:0]      w_hdr_src;
   logic [55:0]      w_sub_src [4];

`ifdef HDMI_PACKET_ECC_EN
   logic [7:0]       r_ecc_h;
   logic [7:0]       r_ecc_s [4];
   logic [7:0]       w_ecc_h_src;
   logic [7:0]       w_ecc_h_next;
   logic [7:0]       w_ecc_s_src  [4];
   logic [7:0]       w_ecc_s_next [4];

   // One LSB-first step of the G(x)=x^8+x^7+x^6+1 LFSR.
   function automatic logic [7:0] ecc_step(input logic [7:0] ecc, input logic bit_in);
      logic fb;
      fb = ecc[0] ^ bit_in;
      return (ecc >> 1) ^ (fb ? 8'h83 : 8'h00);
   endfunction
`endif

   always_comb begin
      w_load = 1'b0;
      if (r_state == S_IDLE)
         w_load = packet_enable && !r_blocked;
      else if (packet_counter == 5'd31)
         w_load = packet_enable && (r_run < RUN_W'(PACKET_COUNT_MAX));
      w_active   = w_load || ((r_state == S_SEND) && (packet_counter != 5'd31));
      w_cnt_next = w_load ? 5'd0 : packet_counter + 5'd1;
   end

   // Stage: pick fresh inputs on a load, otherwise the shifted payload, and form this pixel
   always_comb begin
      w_data    = '0;
      w_hdr_src = w_load ? header : r_hdr_sr;
`ifdef HDMI_PACKET_ECC_EN
      w_ecc_h_src  = w_load ? 8'h00 : r_ecc_h;
      w_ecc_h_next = w_ecc_h_src;
`endif
      if (w_cnt_next < 5'd24) begin
         w_data[0] = w_hdr_src[0];
`ifdef HDMI_PACKET_ECC_EN
         w_ecc_h_next = ecc_step(w_ecc_h_src, w_hdr_src[0]);
`endif
      end else begin
`ifdef HDMI_PACKET_ECC_EN
         w_data[0] = w_ecc_h_src[w_cnt_next[2:0]];
`endif
      end

      for (int i = 0; i < 4; i++) begin
         w_sub_src[i] = w_load ? sub[56*i +: 56] : r_sub_sr[i];
`ifdef HDMI_PACKET_ECC_EN
         w_ecc_s_src[i]  = w_load ? 8'h00 : r_ecc_s[i];
         w_ecc_s_next[i] = w_ecc_s_src[i];
`endif
         if (w_cnt_next < 5'd28) begin
            w_data[1+i] = w_sub_src[i][0];
            w_data[5+i] = w_sub_src[i][1];
`ifdef HDMI_PACKET_ECC_EN
            w_ecc_s_next[i] = ecc_step(ecc_step(w_ecc_s_src[i], w_sub_src[i][0]), w_sub_src[i][1]);
`endif
         end else begin
`ifdef HDMI_PACKET_ECC_EN
            w_data[1+i] = w_ecc_s_src[i][{w_cnt_next[1:0], 1'b0}];
            w_data[5+i] = w_ecc_s_src[i][{w_cnt_next[1:0], 1'b1}];
`endif
         end
      end
   end

   // Stage: registered control and outputs
   always_ff @(posedge clk_pixel) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_run          <= '0;
         r_blocked      <= 1'b0;
         packet_data    <= '0;
         packet_counter <= '0;
         busy           <= 1'b0;
         packet_last    <= 1'b0;
      end else begin
         if (!packet_enable)
            r_blocked <= 1'b0;
         if (w_active) begin
            r_state        <= S_SEND;
            packet_data    <= w_data;
            packet_counter <= w_cnt_next;
            busy           <= 1'b1;
            packet_last    <= (w_cnt_next == 5'd31);
         end else begin
            r_state        <= S_IDLE;
            packet_data    <= '0;
            packet_counter <= '0;
            busy           <= 1'b0;
            packet_last    <= 1'b0;
         end
         if (w_load) begin
            r_run <= (r_state == S_IDLE) ? RUN_W'(1) : r_run + RUN_W'(1);
         end else if (!w_active) begin
            r_run <= '0;
            // A run that hit its limit with the request still high must see a gap first.
            if ((r_state == S_SEND) && packet_enable)
               r_blocked <= 1'b1;
         end
      end
   end

   // Stage: payload shift registers and parity state (no reset; always reloaded before use)
   always_ff @(posedge clk_pixel) begin
      if (w_active) begin
         r_hdr_sr <= w_hdr_src >> 1;
         for (int i = 0; i < 4; i++)
            r_sub_sr[i] <= w_sub_src[i] >> 2;
`ifdef HDMI_PACKET_ECC_EN
         r_ecc_h <= w_ecc_h_next;
         for (int i = 0; i < 4; i++)
            r_ecc_s[i] <= w_ecc_s_next[i];
`endif
      end
   end

endmodule

// File: tb/tb_hdmi_packet_assembler.sv
// Self-checking bench for hdmi_packet_assembler: behavioural packet model plus literal spot checks.
module tb_hdmi_packet_assembler;
   localparam int MAX = 18;

   logic         clk_pixel = 1'b0;
   logic         reset_n = 1'b0;
   logic         packet_enable = 1'b0;
   logic [23:0]  header = '0;
   logic [223:0] sub = '0;
   logic [8:0]   packet_data;
   logic [4:0]   packet_counter;
   logic         busy;
   logic         packet_last;

   hdmi_packet_assembler #(.PACKET_COUNT_MAX(MAX)) dut (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_enable(packet_enable),
      .header(header), .sub(sub), .packet_data(packet_data),
      .packet_counter(packet_counter), .busy(busy), .packet_last(packet_last));

   always #5 clk_pixel = ~clk_pixel;

   int n_tests = 0;
   int n_fail  = 0;
   int busy_cnt = 0;
   int last_cnt = 0;
   logic [8:0] cap [32];
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Parity over the first n bits, LSB first, by the LFSR rule of G(x)=x^8+x^7+x^6+1.
   function automatic logic [7:0] parity(input logic [55:0] bits, input int n);
      logic [7:0] e;
      e = 8'h00;
`ifdef HDMI_PACKET_ECC_EN
      for (int k = 0; k < n; k++)
         e = (e >> 1) ^ ((e[0] ^ bits[k]) ? 8'h83 : 8'h00);
`endif
      return e;
   endfunction

   function automatic logic [8:0] word(input logic [23:0] h, input logic [223:0] s, input int c);
      logic [8:0]  w;
      logic [7:0]  e;
      logic [55:0] sp;
      w = '0;
      if (c < 24) w[0] = h[c];
      else begin
         e = parity({32'b0, h}, 24);
         w[0] = e[c-24];
      end
      for (int i = 0; i < 4; i++) begin
         sp = s[56*i +: 56];
         if (c < 28) begin
            w[1+i] = sp[2*c];
            w[5+i] = sp[2*c+1];
         end else begin
            e = parity(sp, 56);
            w[1+i] = e[2*(c-28)];
            w[5+i] = e[2*(c-28)+1];
         end
      end
      return w;
   endfunction

   function automatic logic [223:0] r224();
      logic [223:0] r;
      for (int k = 0; k < 7; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   // Reference model: which packet and pixel index should be on the outputs.
   bit           m_busy = 1'b0;
   int           m_c = 0;
   int           m_run = 0;
   bit           m_blocked = 1'b0;
   logic [23:0]  m_hdr = '0;
   logic [223:0] m_sub = '0;

   always @(posedge clk_pixel) begin
      if (!reset_n) begin
         m_busy = 1'b0; m_c = 0; m_run = 0; m_blocked = 1'b0;
      end else begin
         if (!m_busy) begin
            if (packet_enable && !m_blocked) begin
               m_busy = 1'b1; m_c = 0; m_run = 1; m_hdr = header; m_sub = sub;
            end
         end else if (m_c < 31) begin
            m_c++;
         end else if (packet_enable && m_run < MAX) begin
            m_c = 0; m_run++; m_hdr = header; m_sub = sub;
         end else begin
            m_busy = 1'b0; m_c = 0; m_run = 0;
            if (packet_enable) m_blocked = 1'b1;
         end
         if (!packet_enable) m_blocked = 1'b0;
      end
   end

   always @(negedge clk_pixel) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_busy));
         check("packet_counter", 32'(packet_counter), m_busy ? m_c : 0);
         check("packet_last", 32'(packet_last), 32'(m_busy && m_c == 31));
         check("packet_data", 32'(packet_data), m_busy ? 32'(word(m_hdr, m_sub, m_c)) : 32'd0);
         if (busy === 1'b1) begin
            cap[packet_counter] = packet_data;
            busy_cnt++;
            if (packet_last === 1'b1) last_cnt++;
         end
      end
   end

   task automatic settle(input int n);
      repeat (n) @(negedge clk_pixel);
      #1;
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 80; k++) begin
         @(negedge clk_pixel);
         if (busy === 1'b0) break;
      end
      if (k == 80) check("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic send(input logic [23:0] h, input logic [223:0] s);
      @(negedge clk_pixel);
      header = h; sub = s; packet_enable = 1'b1;
      @(negedge clk_pixel);
      packet_enable = 1'b0;
      header = $urandom; sub = r224();
      wait_idle();
      settle(1);
   endtask

   logic [7:0]   pbyte;
   logic [223:0] s2;
   bit           ecc_on;

   initial begin
`ifdef HDMI_PACKET_ECC_EN
      ecc_on = 1'b1;
`else
      ecc_on = 1'b0;
`endif
      @(posedge clk_pixel);
      chk_en = 1'b1;
      settle(3);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_data", 32'(packet_data), 32'd0);
      check("reset_counter", 32'(packet_counter), 32'd0);
      check("reset_last", 32'(packet_last), 32'd0);
      @(negedge clk_pixel);
      reset_n = 1'b1;

      // Null packet
      busy_cnt = 0; last_cnt = 0;
      send(24'h0, 224'h0);
      check("null_busy_cycles", busy_cnt, 32);
      check("null_last_count", last_cnt, 1);

      // Header bit 23 only
      send(24'h800000, 224'h0);
      check("hb23_c22", 32'(cap[22][0]), 32'd0);
      check("hb23_c23", 32'(cap[23][0]), 32'd1);
      for (int k = 0; k < 8; k++) pbyte[k] = cap[24+k][0];
      check("hb23_parity", 32'(pbyte), ecc_on ? 32'h83 : 32'h00);
      check("hb23_lanes_c31", 32'(cap[31][8:1]), 32'd0);

      // Subpacket 2 bit 55 only
      s2 = '0;
      s2[56*2+55] = 1'b1;
      send(24'h0, s2);
      check("sb55_c26", 32'(cap[26]), 32'h000);
      check("sb55_c27", 32'(cap[27]), 32'h080);
      check("sb55_c28", 32'(cap[28]), ecc_on ? 32'h088 : 32'h000);
      check("sb55_c29", 32'(cap[29]), 32'h000);
      check("sb55_c31", 32'(cap[31]), ecc_on ? 32'h080 : 32'h000);

      // Random single packets with random gaps
      for (int p = 0; p < 6; p++) begin
         settle($urandom_range(0, 3));
         send($urandom, r224());
      end

      // Back-to-back run with enable held high, payload changing every cycle
      busy_cnt = 0; last_cnt = 0;
      for (int k = 0; k < 20*32; k++) begin
         @(negedge clk_pixel);
         packet_enable = 1'b1; header = $urandom; sub = r224();
      end
      @(negedge clk_pixel);
      packet_enable = 1'b0;
      wait_idle();
      settle(1);
      check("b2b_busy_cycles", busy_cnt, 18*32);
      check("b2b_packet_count", last_cnt, 18);

      // Reset mid-packet, with a simultaneous request that must lose
      @(negedge clk_pixel);
      header = $urandom; sub = r224(); packet_enable = 1'b1;
      @(negedge clk_pixel);
      packet_enable = 1'b0;
      begin
         int k;
         for (k = 0; k < 40; k++) begin
            if (packet_counter === 5'd10) break;
            @(negedge clk_pixel);
         end
         if (k == 40) check("reach_c10_timeout", 32'(packet_counter), 32'd10);
      end
      reset_n = 1'b0; packet_enable = 1'b1;
      settle(1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_data", 32'(packet_data), 32'd0);
      check("rst_mid_counter", 32'(packet_counter), 32'd0);
      @(negedge clk_pixel);
      reset_n = 1'b1; packet_enable = 1'b0;
      send(24'h800000, 224'h0);
      for (int k = 0; k < 8; k++) pbyte[k] = cap[24+k][0];
      check("post_rst_parity", 32'(pbyte), ecc_on ? 32'h83 : 32'h00);
      send($urandom, r224());

      settle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/hdmi_packet_assembler.md
# hdmi_packet_assembler

Serialises one HDMI data island packet (24-bit header plus four 56-bit subpackets) into the per-pixel 9-bit data island stream consumed by the `hdmi` TMDS stage, generating BCH ECC parity on the fly. It sits directly upstream of `hdmi` in the `clk_pixel` domain. It supplies channel 0 bit 2 and channels 1 and 2 bits 3:0 for each of the 32 pixel clocks of a packet. `hdmi` still owns hsync, vsync and the first-cycle flag.

## Interface
- `PACKET_COUNT_MAX`, default 18: maximum packets accepted back-to-back in one run of `packet_enable` without a gap. Requests beyond this are ignored until the next gap.
- `clk_pixel`  in  1  pixel clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `packet_enable`  in  1  request: latch `header`/`sub` at this edge; the 32-cycle packet begins next cycle.
- `header`  in  24  HB2:HB0, bit 0 transmitted first.
- `sub`  in  224  subpacket i at bits [56i+55:56i], bit 0 first.
- `packet_data`  out  9  {ch2[3:0], ch1[3:0], ch0_bit2}.
- `packet_counter`  out  5  index 0..31 of the pixel currently on `packet_data`.
- `busy`  out  1  `packet_data` is valid for this cycle.
- `packet_last`  out  1  high when `packet_counter` == 31.

## Operation
- Interface decision: one clock, `clk_pixel`. `reset_n` is synchronous and active-low.
- States:
  - IDLE: `busy`=0, `packet_data`=0.
  - SEND: 32 cycles, counter 0..31.
- IDLE→SEND when `packet_enable`=1. The inputs are latched into shift registers and all five ECC registers are cleared.
- SEND, counter 31:
  - If `packet_enable`=1 and the run count < `PACKET_COUNT_MAX`: reload the inputs, counter→0, stay in SEND. There is no gap cycle.
  - Otherwise: go to IDLE and clear the run count.
- `packet_enable` in SEND at counter ≠ 31 is ignored.
- Header, counter c in 0..23:
  - ch0_bit2 = header bit c.
  - ECC update: fb = ecc[0]^bit; ecc ← (ecc>>1) ^ (fb ? 8'h83 : 0).
- Header, c in 24..31: ch0_bit2 = ecc_h[c-24], LSB first. The ECC is frozen.
- Subpacket i, c in 0..27:
  - ch1[i] = sub_i bit 2c.
  - ch2[i] = sub_i bit 2c+1.
  - ECC update is applied twice per cycle: even bit first, then odd bit.
- Subpacket i, c in 28..31:
  - ch1[i] = ecc_i[2(c-28)].
  - ch2[i] = ecc_i[2(c-28)+1].
- The generator polynomial is G(x)=x^8+x^7+x^6+1, implemented as an LSB-first LFSR.
- All arithmetic is modulo 2. The counter is 5 bits and wraps 31→0 only on reload.

## Timing
- Reset (`reset_n`=0 at an edge): state IDLE, `packet_data`=0, `packet_counter`=0, `busy`=0, `packet_last`=0, run count 0. Reset overrides a packet in flight, with no partial completion.
- Latency:
  - `packet_enable` sampled at edge E.
  - Counter 0 data is registered at E+1, so `busy` is high from E+1 through E+32.
  - All outputs are registered.
- Back-to-back packets:
  - `packet_enable` must be high in the cycle where `packet_last`=1.
  - The next packet's counter 0 follows immediately.
  - Inputs need to be stable only at the sampling edge.
- `packet_enable` together with `reset_n`=0: reset wins.

## Configuration
- `HDMI_PACKET_ECC_EN` defined: ECC is computed as above.
- Undefined:
  - The ECC registers and LFSR logic are removed.
  - Parity positions (header c 24..31, subpacket c 28..31) are driven 0.
  - All other timing is identical.

## Test plan
- Null packet: `header`=0, `sub`=0, one `packet_enable` pulse → 32 cycles of `packet_data`=0, `busy` high exactly 32 cycles, `packet_last` at the 32nd.
- Header bit 23 only set → ch0_bit2 is 0 for c 0..22, 1 at c 23. Parity at c 24..31 = 1,1,0,0,0,0,0,1 (ECC 8'h83).
- Subpacket 2 bit 55 only set:
  - ch2[2]=1 at c 27; all other data bits 0.
  - Parity (ch1[2],ch2[2]) at c 28..31 = (1,1),(0,0),(0,0),(0,1).
  - Other lanes all 0.
- Back-to-back: `packet_enable` held high for 20×32 cycles → 18 contiguous packets, `busy` drops after the 18th, counter sequence is 0..31 with no gaps. Random payloads must match the reference model.
- Reset mid-packet: assert `reset_n`=0 at counter 10 → next cycle all outputs are 0. A new `packet_enable` starts at counter 0 with a fresh ECC. Compare against the model.
- Build without `HDMI_PACKET_ECC_EN`, repeating the header-bit-23 scenario → parity cycles are all 0, and data bits and timing are unchanged.
